ps2_kbd_rx: RTL
===============

Name: ps2_kbd_rx

Overview:
- PS/2 keyboard receiver that sits directly upstream of the keyboard matrix/decoder block. It consumes the raw ps2_kbd_clk/ps2_kbd_data lines delivered by the ARM I/O block.
- Reception chain: synchronizes and de-glitches the lines, deserializes 11-bit frames, checks start/parity/stop, and folds E0/F0 prefixes into flags.
- Output: a small first-word-fall-through FIFO of decoded scancode events, read by the keyboard block at its own pace.

Parameters:
- FILT, 8: consecutive identical samples required to accept a new filtered ps2_clk level.
- TIMEOUT, 65536: clk_sys cycles allowed without a filtered falling edge while mid-frame.
- DEPTH_LOG2, 3: FIFO depth is 2^DEPTH_LOG2 entries.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock line; asynchronous.
- ps2_data  in  1  raw PS/2 data line; asynchronous.
- rd  in  1  pop the head entry; ignored when valid=0.
- valid  out  1  FIFO non-empty.
- code  out  8  head entry scancode.
- extended  out  1  head entry was preceded by E0.
- release  out  1  head entry was preceded by F0.
- err  out  1  one-cycle pulse on frame error or timeout.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full; cleared only by reset.

Behaviour:
- Reset (async): all outputs 0; FIFO empty; prefix flags clear; FSM in IDLE; filtered clock = 1; filter counter 0.
- Input conditioning:
  - 2-FF synchronizer on both lines.
  - Filtered clock changes only after FILT consecutive synchronized samples differ from its current value.
  - A filtered 1->0 transition is a "fall" event. Data is sampled (synchronized) on the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 -> DATA; bitcnt=0, parity accumulator=0. Fall with data=1 is ignored (no err).
  - DATA: each fall shifts data into shreg LSB-first and XORs it into parity; after the 8th bit -> PARITY.
  - PARITY: on fall, require (XOR of 8 data bits ^ sampled bit) = 1 (odd parity); latch pass/fail; -> STOP.
  - STOP: on fall, require data=1. If parity and stop are both good, go to the decode step; otherwise pulse err. Then -> IDLE.
- Timeout:
  - Counter resets on every fall and is held at 0 in IDLE.
  - Reaching TIMEOUT-1 in any state other than IDLE -> IDLE, pulse err, clear prefix flags.
- Decode, in the cycle after the good stop bit:
  - 0xE0: set ext_flag; nothing pushed.
  - 0xF0: set rel_flag; nothing pushed.
  - Any other byte (including 0xAA, 0xFA, 0xE1): push {ext_flag, rel_flag, byte}; clear both flags.
  - Any frame error or timeout clears both flags.
- Latency: valid rises exactly 2 clk_sys after the fall cycle of the stop bit when the FIFO was empty.
- FIFO:
  - Entries are 10 bits; first-word-fall-through; code/extended/release always show the head entry.
  - Head outputs read 0 when empty.
  - Pop and push in the same cycle: both occur.
  - Full with no pop in the same cycle: the push is dropped and overflow is set.
  - Full with a pop in the same cycle: the push is accepted.
  - rd with valid=0 has no effect.
  - Pointers wrap modulo 2^DEPTH_LOG2; an extra pointer bit distinguishes full from empty.
- Simultaneous events: err and push never coincide, because decode follows only a good frame.
- Reset mid-frame: the frame is lost silently and nothing is pushed.

Decomposition:
- Shared package (ps2_pkg): localparams PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_REL=8'hF0; FSM state enum; packed struct ps2_event_t {extended, release, code[7:0]}.
- One natural sub-module, ps2_evt_fifo: generic FWFT FIFO with parameters WIDTH and DEPTH_LOG2, ports wr/din/rd/dout/empty/full.
- The receiver FSM, filter and timeout stay in ps2_kbd_rx.

Test Plan:
- Frame for 0x1C with parity 0, at a 12.5 kHz PS/2 clock -> valid=1 exactly 2 cycles after the stop fall; code=0x1C, extended=0, release=0; rd -> valid=0.
- Sequence E0 F0 74 -> exactly one entry with code=0x74, extended=1, release=1; the next plain 0x74 has both flags 0.
- 0x1C sent with a wrong parity bit -> one err pulse, no entry; a following good 0x1C is pushed normally.
- Line stopped after 4 data bits for TIMEOUT cycles -> err pulse, FSM returns to IDLE; the next full frame 0x29 decodes correctly.
- Nine frames 0x01..0x09 with DEPTH_LOG2=3 and no rd -> the FIFO holds 0x01..0x08 and overflow=1. Then pop and push in the same cycle while full -> entry accepted, count stays 8.
- 2-cycle glitch pulses on ps2_clk with FILT=8 -> no fall detected, no state change. Also assert reset mid-frame -> all outputs 0 and the next frame is received intact.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, FSM state and event record for the PS/2 keyboard receiver.
package ps2_pkg;
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} ps2_state_t;
  // "release" is a reserved word, so the break-code flag is named released.
  typedef struct packed {
    logic       extended;
    logic       released;
    logic [7:0] code;
  } ps2_event_t;
endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: first-word-fall-through FIFO of 2^DEPTH_LOG2 entries.
// Ports: clk_sys/reset (async, active high); wr/din push; rd pops the head
// (ignored when empty); dout is the head entry (0 when empty); empty/full flags.
module ps2_evt_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wp, rp;
  logic                rd_en, wr_en;
  assign empty = wp == rp;
  // Extra MSB differs when the write pointer has lapped the read pointer.
  assign full  = wp[DEPTH_LOG2] != rp[DEPTH_LOG2] && wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0];
  assign rd_en = rd && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is then legal.
  assign wr_en = wr && (!full || rd_en);
  assign dout  = empty ? '0 : mem[rp[DEPTH_LOG2-1:0]];
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (DEPTH_LOG2+1)'(wr_en);
      rp <= rp + (DEPTH_LOG2+1)'(rd_en);
    end
  always_ff @(posedge clk_sys)
    if (wr_en) mem[wp[DEPTH_LOG2-1:0]] <= din;
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver; filters the lines, deframes bytes, folds E0/F0 prefixes, queues events.
// Ports: clk_sys, reset (async, active high); ps2_clk/ps2_data raw lines;
// rd pops the head event; valid/code/extended/released show the head event;
// err pulses on frame error or timeout; overflow is sticky after a dropped event.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILT       = 8,
  parameter int TIMEOUT    = 65536,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  output logic       valid,
  output logic [7:0] code,
  output logic       extended,
  output logic       released,
  output logic       err,
  output logic       overflow
);
  localparam int FW = $clog2(FILT + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [FW-1:0] F_MAX  = FW'(FILT - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);
  ps2_state_t  state, state_n;
  logic        c_s1, c_s2, d_s1, d_s;
  logic        fclk;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic        fall, tmo;
  logic [2:0]  bitcnt;
  logic [7:0]  shreg;
  logic        par, par_ok;
  logic        dec_v, ext_flag, rel_flag;
  logic        start, shift, par_smp, stop_smp, frame_good, err_set;
  logic        push, empty, full;
  ps2_event_t  head;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s  <= 1'b1;
    end else begin
      c_s1 <= ps2_clk;
      c_s2 <= c_s1;
      d_s1 <= ps2_data;
      d_s  <= d_s1;
    end
  // The filtered clock flips only after FILT consecutive differing samples;
  // fall marks the cycle in which the filtered clock is about to go low.
  assign fall = fclk && !c_s2 && fcnt == F_MAX;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      fclk <= 1'b1;
      fcnt <= '0;
    end else begin
      fclk <= (c_s2 != fclk && fcnt == F_MAX) ? c_s2 : fclk;
      fcnt <= (c_s2 == fclk || fcnt == F_MAX) ? '0 : fcnt + 1'b1;
    end
  assign tmo = state != S_IDLE && tcnt == TO_MAX;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (fall && !d_s) state_n = S_DATA;
      S_DATA:   if (fall && bitcnt == 3'd7) state_n = S_PARITY;
      S_PARITY: if (fall) state_n = S_STOP;
      S_STOP:   if (fall) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (tmo) state_n = S_IDLE;
  end
  // A timeout takes priority over a stop bit sampled in the same cycle.
  always_comb begin
    start      = state == S_IDLE && fall && !d_s;
    shift      = state == S_DATA && fall;
    par_smp    = state == S_PARITY && fall;
    stop_smp   = state == S_STOP && fall && !tmo;
    frame_good = stop_smp && par_ok && d_s;
    err_set    = (stop_smp && !(par_ok && d_s)) || tmo;
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      tcnt     <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      par_ok   <= 1'b0;
      dec_v    <= 1'b0;
      err      <= 1'b0;
      ext_flag <= 1'b0;
      rel_flag <= 1'b0;
    end else begin
      tcnt   <= (state == S_IDLE || fall) ? '0 : tcnt + 1'b1;
      bitcnt <= start ? 3'd0 : shift ? bitcnt + 3'd1 : bitcnt;
      shreg  <= shift ? {d_s, shreg[7:1]} : shreg;
      par    <= start ? 1'b0 : shift ? par ^ d_s : par;
      par_ok <= par_smp ? par ^ d_s : par_ok;
      dec_v  <= frame_good;
      err    <= err_set;
      // shreg stays stable in IDLE, so the decode cycle can read it directly.
      if (err_set) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else if (dec_v) begin
        ext_flag <= shreg == PS2_PREFIX_EXT || (shreg == PS2_PREFIX_REL && ext_flag);
        rel_flag <= shreg == PS2_PREFIX_REL || (shreg == PS2_PREFIX_EXT && rel_flag);
      end
    end
  assign push = dec_v && shreg != PS2_PREFIX_EXT && shreg != PS2_PREFIX_REL;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) overflow <= 1'b0;
    else overflow <= overflow || (push && full && !(rd && valid));
  ps2_evt_fifo #(.WIDTH($bits(ps2_event_t)), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk_sys(clk_sys),
    .reset  (reset),
    .wr     (push),
    .din    ({ext_flag, rel_flag, shreg}),
    .rd     (rd),
    .dout   (head),
    .empty  (empty),
    .full   (full)
  );
  assign valid    = !empty;
  assign code     = head.code;
  assign extended = head.extended;
  assign released = head.released;
endmodule
